// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: shares one single-port RAM (1-cycle read latency)
// between the CPU memory-mapped port and VGA scanout, VGA first with a CPU starvation guard.
//
// state  | meaning
// IDLE   | no CPU read outstanding; CPU may be granted
// CPU_RD | CPU read granted last cycle; its data is on ram_rdata now
module vga_fb_arbiter #(
  parameter logic [3:0] FB_BASE    = 4'hC,
  parameter int         FB_AW      = 12,
  parameter logic [3:0] STARVE_MAX = 4'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             vga_req,
  input  logic [FB_AW-1:0] vga_addr,
  output logic             vga_ack,
  output logic [15:0]      vga_rdata,
  output logic             vga_rvalid,
  output logic [FB_AW-1:0] ram_addr,
  output logic             ram_re,
  output logic             ram_we,
  output logic [15:0]      ram_wdata,
  input  logic [15:0]      ram_rdata
);

  typedef enum logic {IDLE, CPU_RD} state_t;

  state_t           state, state_nxt;
  logic [3:0]       starve_cnt, starve_nxt;
  logic             vga_pend;
  logic [FB_AW-1:0] addr_q;
  logic [15:0]      wdata_q, cpu_rdata_q, vga_rdata_q;
  logic             cpu_hit, cpu_elig, gnt_cpu, gnt_vga;

  always_comb begin
    cpu_hit   = (cpu_re | cpu_we) && (cpu_addr[15:12] == FB_BASE);
    cpu_elig  = (state == IDLE) && cpu_hit;
    gnt_cpu   = cpu_elig && (!vga_req || (starve_cnt == STARVE_MAX));
    gnt_vga   = !gnt_cpu && vga_req;
    state_nxt = (gnt_cpu && !cpu_we) ? CPU_RD : IDLE;

    starve_nxt = starve_cnt;
    if (gnt_cpu || !cpu_hit)
      starve_nxt = 4'd0;
    else if (cpu_elig && (starve_cnt < STARVE_MAX))
      starve_nxt = starve_cnt + 4'd1;

    // Address and write data hold their last driven values when nobody is granted
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    vga_ack   = 1'b0;
    cpu_stall = 1'b0;
    if (gnt_cpu) begin
      ram_addr = cpu_addr[FB_AW-1:0];
      if (cpu_we) begin
        ram_we    = 1'b1;
        ram_wdata = cpu_wdata;
      end else begin
        ram_re    = 1'b1;
        cpu_stall = 1'b1;
      end
    end else if (gnt_vga) begin
      ram_re   = 1'b1;
      ram_addr = vga_addr;
      vga_ack  = 1'b1;
    end
    if (cpu_elig && !gnt_cpu)
      cpu_stall = 1'b1;

    if (!rst_n) begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      vga_ack   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  // Read data is steered by who owned last cycle's read, then held per requester
  assign cpu_rdata  = (rst_n && (state == CPU_RD)) ? ram_rdata : cpu_rdata_q;
  assign vga_rdata  = (rst_n && vga_pend) ? ram_rdata : vga_rdata_q;
  assign vga_rvalid = rst_n & vga_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      vga_pend    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      vga_pend   <= gnt_vga;
      if (gnt_cpu || gnt_vga)
        addr_q <= ram_addr;
      if (ram_we)
        wdata_q <= ram_wdata;
      if (state == CPU_RD)
        cpu_rdata_q <= ram_rdata;
      if (vga_pend)
        vga_rdata_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed cycles with literal checks, plus a
// transaction-level model compared against every output on every cycle.
module tb_vga_fb_arbiter;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, vga_rdata, ram_wdata, ram_rdata;
  logic        cpu_re, cpu_we, cpu_stall, vga_req, vga_ack, vga_rvalid, ram_re, ram_we;
  logic [11:0] vga_addr, ram_addr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM attached to the DUT, and an independent copy kept by the model
  logic [15:0] mem   [4096];
  logic [15:0] m_mem [4096];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]   = 16'(i * 7 + 3);
      m_mem[i] = 16'(i * 7 + 3);
    end
    mem[12'h020] = 16'h1234; m_mem[12'h020] = 16'h1234;
    mem[12'h005] = 16'h0F0F; m_mem[12'h005] = 16'h0F0F;
    ram_rdata = 16'h0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one grant per cycle; transactions tracked as pending words
  bit          m_valid = 0;
  int          m_starve;
  bit          m_cpu_pend, m_vga_pend;
  logic [15:0] m_cpu_word, m_vga_word, m_cpu_hold, m_vga_hold, m_last_wdata;
  logic [11:0] m_last_addr;

  always @(negedge clk) begin
    bit hit, elig, gc, gv;
    logic [11:0] ca;
    ca   = cpu_addr[11:0];
    hit  = (cpu_re || cpu_we) && (cpu_addr[15:12] == 4'hC);
    elig = !m_cpu_pend && hit;
    gc   = elig && (!vga_req || m_starve == STARVE);
    gv   = !gc && vga_req;
    if (!rst_n) begin
      chk("rst_stall", cpu_stall, 0);
      chk("rst_ack", vga_ack, 0);
      chk("rst_ram_re", ram_re, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_rvalid", vga_rvalid, 0);
      m_valid = 1; m_starve = 0; m_cpu_pend = 0; m_vga_pend = 0;
      m_cpu_hold = 0; m_vga_hold = 0; m_last_addr = 0; m_last_wdata = 0;
    end else if (m_valid) begin
      chk("m_stall", cpu_stall, elig && !(gc && cpu_we));
      chk("m_ack", vga_ack, gv);
      chk("m_ram_re", ram_re, gv || (gc && !cpu_we));
      chk("m_ram_we", ram_we, gc && cpu_we);
      chk("m_ram_addr", ram_addr, gc ? ca : (gv ? vga_addr : m_last_addr));
      chk("m_ram_wdata", ram_wdata, (gc && cpu_we) ? cpu_wdata : m_last_wdata);
      chk("m_cpu_rdata", cpu_rdata, m_cpu_pend ? m_cpu_word : m_cpu_hold);
      chk("m_rvalid", vga_rvalid, m_vga_pend);
      chk("m_vga_rdata", vga_rdata, m_vga_pend ? m_vga_word : m_vga_hold);
      if (m_cpu_pend) m_cpu_hold = m_cpu_word;
      if (m_vga_pend) m_vga_hold = m_vga_word;
      m_cpu_pend = gc && !cpu_we;
      m_vga_pend = gv;
      if (gc) begin
        m_last_addr = ca;
        if (cpu_we) begin
          m_last_wdata = cpu_wdata;
          m_mem[ca] = cpu_wdata;
        end else m_cpu_word = m_mem[ca];
      end else if (gv) begin
        m_last_addr = vga_addr;
        m_vga_word = m_mem[vga_addr];
      end
      if (gc || !hit) m_starve = 0;
      else if (elig && m_starve < STARVE) m_starve++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_re = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    vga_req = 0; vga_addr = 12'h0;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    @(negedge clk);
    nxt(); @(negedge clk);
    nxt(); rst_n = 1; @(negedge clk);
    chk("post_rst_cpu_rdata", cpu_rdata, 16'h0);
    chk("post_rst_rvalid", vga_rvalid, 0);

    // CPU write completes with no stall
    nxt(); cpu_we = 1; cpu_addr = 16'hC010; cpu_wdata = 16'hAAAA; @(negedge clk);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 12'h010);
    chk("wr_ram_wdata", ram_wdata, 16'hAAAA);
    chk("wr_stall", cpu_stall, 0);
    nxt(); idle_in(); @(negedge clk);
    chk("idle_ram_we", ram_we, 0);
    chk("idle_wdata_hold", ram_wdata, 16'hAAAA);
    chk("idle_addr_hold", ram_addr, 12'h010);

    // CPU read: one stall cycle
    nxt(); cpu_re = 1; cpu_addr = 16'hC020; @(negedge clk);
    chk("rd_n_stall", cpu_stall, 1);
    chk("rd_n_ram_re", ram_re, 1);
    nxt(); @(negedge clk);
    chk("rd_n1_stall", cpu_stall, 0);
    chk("rd_n1_rdata", cpu_rdata, 16'h1234);

    // VGA priority with starvation guard
    nxt(); vga_req = 1; vga_addr = 12'h005; @(negedge clk);
    chk("starve_ack1", vga_ack, 1);
    chk("starve_stall1", cpu_stall, 1);
    for (int i = 2; i <= 4; i++) begin
      nxt(); @(negedge clk);
      chk("starve_ack", vga_ack, 1);
      chk("starve_stall", cpu_stall, 1);
    end
    nxt(); @(negedge clk);
    chk("forced_ack", vga_ack, 0);
    chk("forced_ram_re", ram_re, 1);
    chk("forced_ram_addr", ram_addr, 12'h020);
    nxt(); @(negedge clk);
    chk("resume_ack", vga_ack, 1);
    chk("resume_stall", cpu_stall, 0);
    chk("resume_cpu_rdata", cpu_rdata, 16'h1234);
    chk("resume_starve", dut.starve_cnt, 0);
    nxt(); idle_in(); @(negedge clk);
    chk("resume_rvalid", vga_rvalid, 1);
    chk("resume_vga_rdata", vga_rdata, 16'h0F0F);

    // CPU read data and VGA read data in adjacent cycles do not cross
    nxt(); cpu_re = 1; cpu_addr = 16'hC010; @(negedge clk);
    chk("x_n_stall", cpu_stall, 1);
    nxt(); vga_req = 1; vga_addr = 12'h005; @(negedge clk);
    chk("x_n1_cpu_rdata", cpu_rdata, 16'hAAAA);
    chk("x_n1_ack", vga_ack, 1);
    nxt(); idle_in(); @(negedge clk);
    chk("x_n2_rvalid", vga_rvalid, 1);
    chk("x_n2_vga_rdata", vga_rdata, 16'h0F0F);
    chk("x_n2_cpu_rdata", cpu_rdata, 16'hAAAA);

    // Non-frame-buffer CPU access is ignored
    nxt(); cpu_re = 1; cpu_addr = 16'h1000; vga_req = 1; vga_addr = 12'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nofb_stall", cpu_stall, 0);
      chk("nofb_ack", vga_ack, 1);
      chk("nofb_starve", dut.starve_cnt, 0);
      nxt();
    end
    idle_in(); @(negedge clk);

    // Read and write strobes together act as a write
    nxt(); cpu_re = 1; cpu_we = 1; cpu_addr = 16'hC030; cpu_wdata = 16'h5555; @(negedge clk);
    chk("rw_ram_we", ram_we, 1);
    chk("rw_ram_re", ram_re, 0);
    chk("rw_stall", cpu_stall, 0);
    nxt(); cpu_we = 0; @(negedge clk);
    nxt(); @(negedge clk);
    chk("rw_readback", cpu_rdata, 16'h5555);
    nxt(); idle_in(); @(negedge clk);

    // Reset in the data cycle of a CPU read
    nxt(); cpu_re = 1; cpu_addr = 16'hC020; @(negedge clk);
    chk("mr_n_stall", cpu_stall, 1);
    nxt(); rst_n = 0; @(negedge clk);
    chk("mr_rst_stall", cpu_stall, 0);
    chk("mr_rst_rvalid", vga_rvalid, 0);
    nxt(); rst_n = 1; @(negedge clk);
    chk("mr_after_cpu_rdata", cpu_rdata, 16'h0);
    chk("mr_after_stall", cpu_stall, 1);
    chk("mr_after_ram_re", ram_re, 1);
    nxt(); @(negedge clk);
    chk("mr_done_stall", cpu_stall, 0);
    chk("mr_done_rdata", cpu_rdata, 16'h1234);
    nxt(); idle_in(); @(negedge clk);
    nxt(); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
